// File: rtl/pwm_timebase.sv
`default_nettype none
// ============================================================================
// Module      : pwm_timebase
// Description : PWM time-base counter. It supports a programmable period, a
//               clock prescaler and edge-aligned (sawtooth) or center-aligned
//               (triangle) counting. The period, prescale and mode registers
//               are shadowed and load only at a cycle boundary, so the output
//               waveform changes without glitches.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_timebase #(
    parameter int                WIDTH      = 8,
    parameter int                PRESC_W    = 4,
    parameter logic [WIDTH-1:0]  RST_PERIOD = {WIDTH{1'b1}}
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               mode,
    input  logic [WIDTH-1:0]   period_in,
    input  logic [PRESC_W-1:0] prescale_in,
    input  logic               update,
    output logic [WIDTH-1:0]   count,
    output logic               dir,
    output logic               zero_tick,
    output logic               period_tick,
    output logic               upd_ack
);

    localparam logic              c_MODE_EDGE = 1'b0;
    localparam logic [WIDTH-1:0]  c_CNT_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PRESC_W-1:0] c_PRE_ONE  = {{(PRESC_W-1){1'b0}}, 1'b1};

    // Architectural state
    logic [WIDTH-1:0]   r_count;
    logic               r_dir;
    logic               r_zero_tick;
    logic               r_period_tick;
    logic               r_upd_ack;
    logic [WIDTH-1:0]   r_per_act;
    logic [PRESC_W-1:0] r_presc_act;
    logic               r_mode_act;
    logic [PRESC_W-1:0] r_pre_cnt;
    logic               r_pending;

    // Next-state terms
    logic               w_step;
    logic               w_boundary;
    logic               w_load;
    logic [WIDTH-1:0]   w_per_nxt;
    logic [PRESC_W-1:0] w_presc_nxt;
    logic               w_mode_nxt;
    logic [WIDTH-1:0]   w_count_nxt;
    logic               w_dir_nxt;
    logic [PRESC_W-1:0] w_pre_nxt;
    logic               w_zero_nxt;
    logic               w_period_nxt;

    // Step, boundary, shadow load and counter next-state decode
    always_comb begin
        // A step happens when the prescaler reaches its terminal value.
        // The >= guards against a prescaler value left above a smaller load.
        w_step = enable && (r_pre_cnt >= r_presc_act);

        // Edge: the step that wraps to 0. Center: the turn-up step at 0.
        // A zero period in center mode never turns down, so every step there
        // is treated as a boundary to let a pending update get through.
        if (r_mode_act == c_MODE_EDGE) begin
            w_boundary = (r_count >= r_per_act);
        end else begin
            w_boundary = (r_dir && (r_count == '0)) || (r_per_act == '0);
        end

        // While disabled there is no cycle in progress: load right away.
        w_load = (r_pending || update) && (!enable || (w_step && w_boundary));

        w_per_nxt   = w_load ? period_in   : r_per_act;
        w_presc_nxt = w_load ? prescale_in : r_presc_act;
        w_mode_nxt  = w_load ? mode        : r_mode_act;

        w_count_nxt = r_count;
        w_dir_nxt   = r_dir;

        if (w_step) begin
            if (w_boundary) begin
                // Boundary step: restart the cycle using the (possibly new)
                // period. The direction always restarts upwards.
                w_dir_nxt = 1'b0;
                if ((r_mode_act == c_MODE_EDGE) || (w_per_nxt == '0)) begin
                    w_count_nxt = '0;
                end else begin
                    w_count_nxt = c_CNT_ONE;
                end
            end else if (r_mode_act == c_MODE_EDGE) begin
                w_count_nxt = r_count + c_CNT_ONE;
                w_dir_nxt   = 1'b0;
            end else if (!r_dir) begin
                if (r_count >= r_per_act) begin
                    w_dir_nxt   = 1'b1;
                    w_count_nxt = r_per_act - c_CNT_ONE;
                end else begin
                    w_count_nxt = r_count + c_CNT_ONE;
                end
            end else begin
                w_count_nxt = r_count - c_CNT_ONE;
            end
        end else if (w_load && (w_mode_nxt == c_MODE_EDGE)) begin
            // Load while disabled: count/dir hold, but edge mode never
            // reports a downward direction.
            w_dir_nxt = 1'b0;
        end

        if (!enable || w_step) begin
            w_pre_nxt = '0;
        end else begin
            w_pre_nxt = r_pre_cnt + c_PRE_ONE;
        end

        w_zero_nxt   = w_step && (w_count_nxt == '0);
        w_period_nxt = w_step && (w_count_nxt == w_per_nxt);
    end

    // Register all state and outputs; asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count       <= '0;
            r_dir         <= 1'b0;
            r_zero_tick   <= 1'b0;
            r_period_tick <= 1'b0;
            r_upd_ack     <= 1'b0;
            r_per_act     <= RST_PERIOD;
            r_presc_act   <= '0;
            r_mode_act    <= c_MODE_EDGE;
            r_pre_cnt     <= '0;
            r_pending     <= 1'b0;
        end else begin
            r_count       <= w_count_nxt;
            r_dir         <= w_dir_nxt;
            r_zero_tick   <= w_zero_nxt;
            r_period_tick <= w_period_nxt;
            r_upd_ack     <= w_load;
            r_per_act     <= w_per_nxt;
            r_presc_act   <= w_presc_nxt;
            r_mode_act    <= w_mode_nxt;
            r_pre_cnt     <= w_pre_nxt;
            r_pending     <= (r_pending || update) && !w_load;
        end
    end

    assign count       = r_count;
    assign dir         = r_dir;
    assign zero_tick   = r_zero_tick;
    assign period_tick = r_period_tick;
    assign upd_ack     = r_upd_ack;

endmodule
`default_nettype wire

// File: tb/tb_pwm_timebase.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_timebase
// Description : Scoreboard testbench for pwm_timebase. Stimulus pushes
//               cycle-tagged expected outputs; a monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_timebase;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       mode;
    logic [7:0] period_in;
    logic [3:0] prescale_in;
    logic       update;
    logic [7:0] count;
    logic       dir;
    logic       zero_tick;
    logic       period_tick;
    logic       upd_ack;

    typedef struct {
        int          cyc;
        logic [7:0]  cnt;
        logic        d;
        logic        z;
        logic        p;
        logic        a;
        logic [63:0] tag;
    } exp_t;

    exp_t q[$];
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [7:0] ctr_c [12] = '{8'd1, 8'd2, 8'd3, 8'd2, 8'd1, 8'd0,
                               8'd1, 8'd2, 8'd3, 8'd2, 8'd1, 8'd0};
    logic       ctr_d [12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                               1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] psc_c [9]  = '{8'd1, 8'd1, 8'd2, 8'd2, 8'd2,
                               8'd0, 8'd0, 8'd0, 8'd1};

    pwm_timebase #(
        .WIDTH      (8),
        .PRESC_W    (4),
        .RST_PERIOD (8'd255)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .mode        (mode),
        .period_in   (period_in),
        .prescale_in (prescale_in),
        .update      (update),
        .count       (count),
        .dir         (dir),
        .zero_tick   (zero_tick),
        .period_tick (period_tick),
        .upd_ack     (upd_ack)
    );

    always #5 clk = ~clk;

    // Cycle index shared by stimulus and monitor
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation tagged with the current cycle
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            n_tests++;
            if (e.cyc < cyc) begin
                n_fail++;
                $display("FAIL %s: expectation for cycle %0d never compared (now %0d)",
                         e.tag, e.cyc, cyc);
            end else if ({count, dir, zero_tick, period_tick, upd_ack} !==
                         {e.cnt, e.d, e.z, e.p, e.a}) begin
                n_fail++;
                $display("FAIL %s cyc %0d: got count=%0d dir=%b zt=%b pt=%b ack=%b, want count=%0d dir=%b zt=%b pt=%b ack=%b",
                         e.tag, cyc, count, dir, zero_tick, period_tick, upd_ack,
                         e.cnt, e.d, e.z, e.p, e.a);
            end
        end
    end

    task automatic expect_at(input int off, input logic [7:0] c, input logic d,
                             input logic z, input logic p, input logic a,
                             input logic [63:0] tag);
        exp_t e;
        e.cyc = cyc + off;
        e.cnt = c;
        e.d   = d;
        e.z   = z;
        e.p   = p;
        e.a   = a;
        e.tag = tag;
        q.push_back(e);
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] cv;

        rst_n = 1'b0; enable = 1'b0; mode = 1'b0;
        period_in = 8'd0; prescale_in = 4'd0; update = 1'b0;
        run(2);
        expect_at(0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, "reset");
        run(1);
        rst_n = 1'b1;

        // Load edge mode, period 4 while disabled: immediate ack
        mode = 1'b0; period_in = 8'd4; prescale_in = 4'd0; update = 1'b1;
        expect_at(1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, "upd_dis");
        run(1);
        update = 1'b0; enable = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            cv = 8'(k % 5);
            expect_at(k, cv, 1'b0, cv == 8'd0, cv == 8'd4, 1'b0, "edge4");
        end
        run(10);

        // Shadow update at count=1: finishes to 4, acks at 0, then period 2
        expect_at(1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, "edge4");
        run(1);
        update = 1'b1; period_in = 8'd2;
        expect_at(1, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0, "shadow");
        run(1);
        update = 1'b0;
        expect_at(1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, "shadow");
        expect_at(2, 8'd4, 1'b0, 1'b0, 1'b1, 1'b0, "shadow");
        expect_at(3, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1, "shd_ack");
        expect_at(4, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, "per2");
        expect_at(5, 8'd2, 1'b0, 1'b0, 1'b1, 1'b0, "per2");
        expect_at(6, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, "per2");
        expect_at(7, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, "per2");
        expect_at(8, 8'd2, 1'b0, 1'b0, 1'b1, 1'b0, "per2");
        run(8);

        // Switch to center mode, period 3, at the edge wrap
        mode = 1'b1; period_in = 8'd3; update = 1'b1;
        expect_at(1, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1, "ctr_ld");
        run(1);
        update = 1'b0;
        for (int k = 0; k < 12; k++) begin
            expect_at(k + 1, ctr_c[k], ctr_d[k], ctr_c[k] == 8'd0,
                      ctr_c[k] == 8'd3, 1'b0, "center3");
        end
        run(12);

        // Back to edge, period 2, prescale 2, loaded at the turn-up step
        mode = 1'b0; period_in = 8'd2; prescale_in = 4'd2; update = 1'b1;
        expect_at(1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1, "psc_ld");
        run(1);
        update = 1'b0;
        for (int k = 0; k < 9; k++) begin
            expect_at(k + 1, psc_c[k], 1'b0, (k == 5), (k == 2), 1'b0, "presc2");
        end
        run(9);

        // Disable holds the count and clears the prescaler
        enable = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            expect_at(k, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, "hold");
        end
        run(4);
        enable = 1'b1;
        expect_at(1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, "reen");
        expect_at(2, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, "reen");
        expect_at(3, 8'd2, 1'b0, 1'b0, 1'b1, 1'b0, "reen");
        run(3);

        // Update while disabled to period 0 (count sits above new period)
        enable = 1'b0; mode = 1'b0; period_in = 8'd0; prescale_in = 4'd0; update = 1'b1;
        expect_at(1, 8'd2, 1'b0, 1'b0, 1'b0, 1'b1, "upd_off");
        run(1);
        update = 1'b0; enable = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            expect_at(k, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, "per0");
        end
        run(3);

        // Period 20, then leave an update pending and reset at count=5
        period_in = 8'd20; update = 1'b1;
        expect_at(1, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1, "ld20");
        run(1);
        update = 1'b0;
        expect_at(1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, "per20");
        expect_at(2, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0, "per20");
        expect_at(3, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, "per20");
        run(3);
        update = 1'b1; period_in = 8'd7;
        expect_at(1, 8'd4, 1'b0, 1'b0, 1'b0, 1'b0, "pend");
        run(1);
        update = 1'b0;
        expect_at(1, 8'd5, 1'b0, 1'b0, 1'b0, 1'b0, "pend");
        run(1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        // Counts from 0 again with period 255; pending update is gone
        for (int k = 1; k <= 257; k++) begin
            cv = 8'(k % 256);
            expect_at(k, cv, 1'b0, cv == 8'd0, cv == 8'd255, 1'b0, "rst255");
        end
        run(259);

        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
